v810_ifq: RTL and testbench
===========================

// Module: v810_ifq
// PURPOSE
// Instruction prefetch queue between the EU decoder and the memory access unit's instruction port.
// - Fetches 32-bit words ahead of execution and buffers them as halfwords.
// - Presents up to two halfwords per cycle (V810 instructions are 16 or 32 bits, halfword aligned).
// - Restarts fetching at a new PC on branch/exception flush.
// PARAMETERS
// DEPTH  4  queue capacity in 32-bit words (power of two, >=2); halfword capacity = 2*DEPTH
// PORTS
// CLK       in   1   clock
// RESn      in   1   reset, asynchronous, active-low
// CE        in   1   global clock enable; all state advances only when CE=1
// FLUSH     in   1   discard queue, restart fetch at FLUSH_PC
// FLUSH_PC  in   32  new PC (bit0 ignored)
// IA        out  32  fetch address to memory unit (word aligned)
// ID        in   32  fetch data, valid when IACK=1
// IREQ      out  1   fetch request
// IACK      in   1   fetch acknowledge (one CE cycle)
// Q_HW0     out  16  halfword at Q_PC
// Q_HW1     out  16  halfword at Q_PC+2
// Q_AVAIL   out  2   valid halfwords presented (0,1,2)
// Q_PC      out  32  address of Q_HW0
// CONS      in   2   halfwords consumed this cycle (0,1,2)
// BEHAVIOUR
// Reset: one clock; reset is asynchronous and active-low (RESn). Outputs: IREQ=0, IA=0, Q_AVAIL=0, Q_PC=0, Q_HW0/1=0.
//   Queue empty, fetch stopped; no fetch until first FLUSH (EU supplies reset vector via FLUSH).
// States: IDLE (stopped/full), FETCH (IREQ=1 awaiting IACK), DRAIN (IREQ=1 for stale access after flush).
// Request rules: IA and IREQ held stable from assertion until IACK; never withdrawn or changed mid-access.
//   IREQ asserted when started and free halfwords >= 2 (after this cycle's CONS). Back-to-back: IACK cycle may
//   re-request next cycle with IA+4.
// Accepted IACK (FETCH): write ID[15:0] then ID[31:16] as successive halfwords, fetch address += 4.
//   First word after flush with FLUSH_PC[1]=1: write ID[31:16] only.
// FLUSH (CE cycle n): queue emptied, Q_AVAIL=0 at n+1; Q_PC=FLUSH_PC&~1; fetch address={FLUSH_PC[31:2],2'b00}.
//   No access outstanding: IREQ=1 with new IA at n+1.
//   Access outstanding (IREQ=1, IACK=0): enter DRAIN, keep old IA/IREQ until IACK, discard ID, new request next cycle.
//   FLUSH with IACK in same cycle: ID discarded, new request at n+1.
//   FLUSH during DRAIN: update target PC only; stay in DRAIN.
//   FLUSH has priority over CONS in the same cycle (CONS ignored).
// Output: Q_AVAIL=min(count,2); Q_HW0/Q_HW1 from read pointer; undefined halfwords driven 0.
// Consume: CONS clipped to Q_AVAIL; read pointer += CONS; Q_PC += 2*CONS (32-bit wrap at FFFFFFFE->0).
// Write and consume in same cycle allowed; count = count + written - consumed, never exceeds 2*DEPTH.
// Pointers wrap modulo 2*DEPTH; full vs empty disambiguated by count, not pointer equality.
// Fetch address wraps FFFFFFFC -> 00000000 silently.
// Latency (no bypass): data returned with IACK in cycle n visible on Q_* at n+1.
// CONFIGURATION
// V810_IFQ_BYPASS_EN defined: when queue empty and IACK accepted (not stale), ID halfwords appear on
//   Q_HW0/Q_HW1/Q_AVAIL combinationally in the same cycle; CONS of them that cycle is honoured and only
//   unconsumed halfwords are written. Not defined: strict one-cycle latency, Q_* purely registered.
// TESTING
// Reset then FLUSH_PC=FFFFFFF0, IACK 2 cycles after each IREQ -> IA=FFFFFFF0,FFFFFFF4,...; Q_PC=FFFFFFF0, Q_AVAIL=2.
// CONS=0 forever, IACK immediate -> exactly DEPTH(4) words fetched, IREQ drops, Q_AVAIL=2, no overwrite.
// FLUSH_PC=00001002, ID=AAAABBBB -> Q_HW0=AAAA, Q_PC=00001002, next IA=00001004.
// FLUSH to 00002000 while IREQ pending at 00001008 -> IA stays 00001008 until IACK, data dropped, then IA=00002000.
// Alternate CONS=1/2 with steady fetch, ID=address -> Q_HW stream matches address halfwords, no gaps/dups.
// With V810_IFQ_BYPASS_EN, empty queue, IACK with ID=12345678 -> same cycle Q_AVAIL=2, Q_HW0=5678, Q_HW1=1234.

Source files
------------

// File: rtl/v810_ifq.sv
// V810 instruction prefetch queue: fetches 32-bit words ahead of the decoder and presents up to two halfwords per cycle.
// Optional feature: define V810_IFQ_BYPASS_EN to present fetched data on Q_* in the acknowledge cycle when the queue is empty.
module v810_ifq #(
  parameter int DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_res_n,
  input  logic        i_ce,
  input  logic        i_flush,
  input  logic [31:0] i_flush_pc,
  output logic [31:0] o_ia,
  input  logic [31:0] i_id,
  output logic        o_ireq,
  input  logic        i_iack,
  output logic [15:0] o_q_hw0,
  output logic [15:0] o_q_hw1,
  output logic [1:0]  o_q_avail,
  output logic [31:0] o_q_pc,
  input  logic [1:0]  i_cons
);

  localparam int HW = 2 * DEPTH;
  localparam int PW = $clog2(HW);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] C_CAP = CW'(HW);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_ireq;
  logic          w_ireq_nxt;
  logic [31:0]   r_ia;
  logic [31:0]   w_ia_nxt;
  logic [31:0]   r_fa;
  logic [31:0]   w_fa_nxt;
  logic          r_odd;
  logic          r_started;
  logic [15:0]   r_mem [HW];
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;
  logic [31:0]   r_q_pc;

  logic          w_live;
  logic          w_byp;
  logic          w_room;
  logic [31:0]   w_flush_fa;
  logic [1:0]    w_in_n;
  logic [15:0]   w_in_hw0;
  logic [15:0]   w_in_hw1;
  logic [15:0]   w_qhw0;
  logic [15:0]   w_qhw1;
  logic [1:0]    w_qavail;
  logic [15:0]   w_hw0;
  logic [15:0]   w_hw1;
  logic [1:0]    w_avail;
  logic [1:0]    w_cons_eff;
  logic [1:0]    w_skip;
  logic [1:0]    w_wr_n;
  logic [1:0]    w_rd_adv;

  assign w_flush_fa = {i_flush_pc[31:2], 2'b00};
  // Only an acknowledge of a live (non-stale) access delivers data; a flush in the same cycle discards it.
  assign w_live     = i_ce & ~i_flush & i_iack & (r_state == S_FETCH);
  assign w_in_n     = w_live ? (r_odd ? 2'd1 : 2'd2) : 2'd0;
  assign w_in_hw0   = r_odd ? i_id[31:16] : i_id[15:0];
  assign w_in_hw1   = i_id[31:16];

`ifdef V810_IFQ_BYPASS_EN
  assign w_byp = w_live & (r_count == CW'(0));
`else
  assign w_byp = 1'b0;
`endif

  always_comb begin
    w_qhw0   = 16'h0000;
    w_qhw1   = 16'h0000;
    w_qavail = 2'd0;
    if (r_count >= CW'(2)) begin
      w_qavail = 2'd2;
      w_qhw0   = r_mem[r_rd];
      w_qhw1   = r_mem[r_rd + PW'(1)];
    end else if (r_count == CW'(1)) begin
      w_qavail = 2'd1;
      w_qhw0   = r_mem[r_rd];
    end else begin
      w_qavail = 2'd0;
    end
  end

  always_comb begin
    w_avail = w_qavail;
    w_hw0   = w_qhw0;
    w_hw1   = w_qhw1;
    if (w_byp) begin
      w_avail = w_in_n;
      w_hw0   = w_in_hw0;
      w_hw1   = r_odd ? 16'h0000 : w_in_hw1;
    end else begin
      w_avail = w_qavail;
    end
  end

  // Bypassed halfwords that are consumed immediately never enter the queue.
  always_comb begin
    w_cons_eff = 2'd0;
    if (i_ce & ~i_flush) begin
      w_cons_eff = (i_cons > w_avail) ? w_avail : i_cons;
    end else begin
      w_cons_eff = 2'd0;
    end
    w_skip      = w_byp ? w_cons_eff : 2'd0;
    w_wr_n      = w_in_n - w_skip;
    w_rd_adv    = w_cons_eff - w_skip;
    w_count_nxt = r_count + CW'(w_in_n) - CW'(w_cons_eff);
    w_room      = (C_CAP - w_count_nxt) >= CW'(2);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ireq_nxt  = r_ireq;
    w_ia_nxt    = r_ia;
    w_fa_nxt    = r_fa;
    if (!i_ce) begin
      w_state_nxt = r_state;
    end else if (i_flush) begin
      w_fa_nxt = w_flush_fa;
      if (r_ireq && !i_iack) begin
        w_state_nxt = S_DRAIN;
      end else begin
        w_state_nxt = S_FETCH;
        w_ireq_nxt  = 1'b1;
        w_ia_nxt    = w_flush_fa;
        w_fa_nxt    = w_flush_fa + 32'd4;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_started && w_room) begin
            w_state_nxt = S_FETCH;
            w_ireq_nxt  = 1'b1;
            w_ia_nxt    = r_fa;
            w_fa_nxt    = r_fa + 32'd4;
          end else begin
            w_ireq_nxt  = 1'b0;
          end
        end
        S_FETCH: begin
          if (i_iack && w_room) begin
            w_ia_nxt    = r_fa;
            w_fa_nxt    = r_fa + 32'd4;
          end else if (i_iack) begin
            w_state_nxt = S_IDLE;
            w_ireq_nxt  = 1'b0;
          end else begin
            w_ireq_nxt  = 1'b1;
          end
        end
        S_DRAIN: begin
          if (i_iack) begin
            w_state_nxt = S_FETCH;
            w_ia_nxt    = r_fa;
            w_fa_nxt    = r_fa + 32'd4;
          end else begin
            w_ireq_nxt  = 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_ireq_nxt  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      r_state <= S_IDLE;
      r_ireq  <= 1'b0;
      r_ia    <= 32'h0000_0000;
      r_fa    <= 32'h0000_0000;
    end else begin
      r_state <= w_state_nxt;
      r_ireq  <= w_ireq_nxt;
      r_ia    <= w_ia_nxt;
      r_fa    <= w_fa_nxt;
    end
  end

  // Count, not pointer equality, distinguishes full from empty.
  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      r_rd      <= PW'(0);
      r_wr      <= PW'(0);
      r_count   <= CW'(0);
      r_q_pc    <= 32'h0000_0000;
      r_odd     <= 1'b0;
      r_started <= 1'b0;
      for (int i = 0; i < HW; i++) begin
        r_mem[i] <= 16'h0000;
      end
    end else if (i_ce) begin
      if (i_flush) begin
        r_rd      <= PW'(0);
        r_wr      <= PW'(0);
        r_count   <= CW'(0);
        r_q_pc    <= {i_flush_pc[31:1], 1'b0};
        r_odd     <= i_flush_pc[1];
        r_started <= 1'b1;
      end else begin
        r_rd    <= r_rd + PW'(w_rd_adv);
        r_wr    <= r_wr + PW'(w_wr_n);
        r_count <= w_count_nxt;
        r_q_pc  <= r_q_pc + {29'd0, w_cons_eff, 1'b0};
        if (w_live) begin
          r_odd <= 1'b0;
        end
        if (w_wr_n != 2'd0) begin
          r_mem[r_wr] <= (w_skip == 2'd1) ? w_in_hw1 : w_in_hw0;
        end
        if (w_wr_n == 2'd2) begin
          r_mem[r_wr + PW'(1)] <= w_in_hw1;
        end
      end
    end
  end

  assign o_ia      = r_ia;
  assign o_ireq    = r_ireq;
  assign o_q_pc    = r_q_pc;
  assign o_q_hw0   = w_hw0;
  assign o_q_hw1   = w_hw1;
  assign o_q_avail = w_avail;

endmodule

// File: tb/tb_v810_ifq.sv
// Self-checking bench for v810_ifq: randomized fetch/consume traffic against a queue-based reference model.
`timescale 1ns/1ps
module tb_v810_ifq;
  localparam int DEPTH = 4;

  logic        i_clk = 1'b0;
  logic        i_res_n, i_ce, i_flush, i_iack, o_ireq;
  logic [31:0] i_flush_pc, o_ia, i_id, o_q_pc;
  logic [15:0] o_q_hw0, o_q_hw1;
  logic [1:0]  o_q_avail, i_cons;

  v810_ifq #(.DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_res_n(i_res_n), .i_ce(i_ce), .i_flush(i_flush), .i_flush_pc(i_flush_pc),
    .o_ia(o_ia), .i_id(i_id), .o_ireq(o_ireq), .i_iack(i_iack),
    .o_q_hw0(o_q_hw0), .o_q_hw1(o_q_hw1), .o_q_avail(o_q_avail), .o_q_pc(o_q_pc), .i_cons(i_cons)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_err = 0;

  // reference model state
  logic [15:0] mq[$];
  logic [31:0] m_pc, m_fa, m_ia;
  logic        m_req, m_stale, m_odd, m_started;

  // memory responder
  logic [31:0] salt;
  logic        hold_ack;
  int          ack_delay, cur_delay, wait_cnt, n_acks;

  // last sampled cycle
  logic        ob_ireq;
  logic [31:0] ob_ia, ob_pc;
  logic [15:0] ob_hw0, ob_hw1;
  logic [1:0]  ob_avail;
  logic [98:0] obs_v, exp_v;
  int          last_cc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ salt;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pc = 32'h0; m_fa = 32'h0; m_ia = 32'h0;
    m_req = 1'b0; m_stale = 1'b0; m_odd = 1'b0; m_started = 1'b0;
    wait_cnt = 0; n_acks = 0;
    cur_delay = (ack_delay < 0) ? $urandom_range(0, 3) : ack_delay;
  endtask

  // One clock: drive at posedge+1, sample mid-cycle, advance the model, return at next posedge+1.
  task automatic cyc(input logic fl, input logic [31:0] fpc, input logic [1:0] cons, input logic ce);
    logic ack;
    logic [15:0] in_hw[$];
    logic [15:0] pres[$];
    int av, cc;
    ack = ce && o_ireq && !hold_ack && (wait_cnt >= cur_delay);
    i_ce = ce; i_flush = fl; i_flush_pc = fpc; i_cons = cons; i_iack = ack; i_id = mem_word(o_ia);
    #4;
    in_hw = {};
    if (ce && ack && m_req && !m_stale && !fl) begin
      if (m_odd) in_hw.push_back(i_id[31:16]);
      else begin in_hw.push_back(i_id[15:0]); in_hw.push_back(i_id[31:16]); end
    end
    pres = mq;
`ifdef V810_IFQ_BYPASS_EN
    if (mq.size() == 0 && in_hw.size() > 0) pres = in_hw;
`endif
    av = (pres.size() > 2) ? 2 : pres.size();
    ob_ireq = o_ireq; ob_ia = o_ia; ob_avail = o_q_avail; ob_hw0 = o_q_hw0; ob_hw1 = o_q_hw1; ob_pc = o_q_pc;
    obs_v = {ob_ireq, ob_ireq ? ob_ia : 32'h0, ob_avail, ob_hw0, ob_hw1, ob_pc};
    exp_v = {m_req, m_req ? m_ia : 32'h0, 2'(av), (av > 0) ? pres[0] : 16'h0, (av > 1) ? pres[1] : 16'h0, m_pc};
    cc = 0;
    if (ce) begin
      if (fl) begin
        mq.delete();
        m_pc = {fpc[31:1], 1'b0};
        m_odd = fpc[1];
        m_started = 1'b1;
        if (m_req && !ack) begin
          m_stale = 1'b1; m_fa = {fpc[31:2], 2'b00};
        end else begin
          m_stale = 1'b0; m_req = 1'b1; m_ia = {fpc[31:2], 2'b00}; m_fa = m_ia + 32'd4;
        end
      end else begin
        cc = (int'(cons) > av) ? av : int'(cons);
        if (mq.size() == 0 && pres.size() > 0 && pres.size() == in_hw.size()) begin
          mq = in_hw;
          repeat (cc) void'(mq.pop_front());
        end else begin
          repeat (cc) void'(mq.pop_front());
          foreach (in_hw[k]) mq.push_back(in_hw[k]);
        end
        m_pc = m_pc + 32'(2 * cc);
        if (m_req && ack) begin
          if (!m_stale) m_odd = 1'b0;
          m_stale = 1'b0;
        end
        if (!m_req || ack) begin
          if (m_started && (2 * DEPTH - mq.size()) >= 2) begin
            m_req = 1'b1; m_ia = m_fa; m_fa = m_fa + 32'd4;
          end else begin
            m_req = 1'b0;
          end
        end
      end
      if (ack) begin
        wait_cnt = 0; n_acks++;
        cur_delay = (ack_delay < 0) ? $urandom_range(0, 3) : ack_delay;
      end else if (o_ireq) begin
        wait_cnt++;
      end
    end
    last_cc = cc;
    @(posedge i_clk); #1;
  endtask

  task automatic test_reset();
    i_res_n = 1'b0; i_ce = 1'b1; i_flush = 1'b0; i_flush_pc = 32'h0; i_iack = 1'b0; i_id = 32'h0; i_cons = 2'd0;
    ack_delay = 0; hold_ack = 1'b0; salt = 32'h0;
    #3;
    n_checks++;
    if ({o_ireq, o_ia, o_q_avail, o_q_hw0, o_q_hw1, o_q_pc} !== 99'h0) begin
      n_err++; $display("FAIL reset: got %h required 0", {o_ireq, o_ia, o_q_avail, o_q_hw0, o_q_hw1, o_q_pc});
    end
    repeat (2) @(posedge i_clk);
    #1; i_res_n = 1'b1;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 32'h0, 2'($urandom_range(0, 2)), 1'b1);
      n_checks++;
      if (obs_v !== exp_v) begin n_err++; $display("FAIL reset_idle cyc%0d: got %h required %h", i, obs_v, exp_v); end
    end
  endtask

  task automatic test_wrap_start();
    ack_delay = 2; cur_delay = 2; salt = $urandom;
    cyc(1'b1, 32'hFFFF_FFF0, 2'd0, 1'b1);
    for (int i = 0; i < 40; i++) begin
      cyc(1'b0, 32'h0, 2'($urandom_range(0, 2)), 1'b1);
      n_checks++;
      if (obs_v !== exp_v) begin n_err++; $display("FAIL wrap_start cyc%0d: got %h required %h", i, obs_v, exp_v); end
    end
  endtask

  task automatic test_fill();
    int a0;
    ack_delay = 0; cur_delay = 0; salt = $urandom;
    cyc(1'b1, 32'h0000_0100, 2'd0, 1'b1);
    a0 = n_acks;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 32'h0, 2'd0, 1'b1);
      n_checks++;
      if (obs_v !== exp_v) begin n_err++; $display("FAIL fill cyc%0d: got %h required %h", i, obs_v, exp_v); end
    end
    n_checks++;
    if (n_acks - a0 != DEPTH || ob_ireq !== 1'b0 || ob_avail !== 2'd2) begin
      n_err++; $display("FAIL fill_words: got words=%0d ireq=%b avail=%0d required words=%0d ireq=0 avail=2", n_acks - a0, ob_ireq, ob_avail, DEPTH);
    end
  endtask

  task automatic test_odd_flush();
    ack_delay = 0; cur_delay = 0; salt = 32'hAAAA_BBBB ^ 32'h0000_1000;
    cyc(1'b1, 32'h0000_1002, 2'd0, 1'b1);
    cyc(1'b0, 32'h0, 2'd0, 1'b1);
    cyc(1'b0, 32'h0, 2'd0, 1'b1);
    n_checks++;
    if (obs_v !== exp_v) begin n_err++; $display("FAIL odd_model: got %h required %h", obs_v, exp_v); end
    n_checks++;
    if (ob_hw0 !== 16'hAAAA || ob_pc !== 32'h0000_1002 || ob_ia !== 32'h0000_1004) begin
      n_err++; $display("FAIL odd_flush: got hw0=%h pc=%h ia=%h required hw0=aaaa pc=00001002 ia=00001004", ob_hw0, ob_pc, ob_ia);
    end
  endtask

  task automatic test_drain();
    ack_delay = 0; cur_delay = 0; hold_ack = 1'b0; salt = $urandom;
    cyc(1'b1, 32'h0000_1000, 2'd0, 1'b1);
    cyc(1'b0, 32'h0, 2'd0, 1'b1);
    cyc(1'b0, 32'h0, 2'd0, 1'b1);
    hold_ack = 1'b1;
    cyc(1'b0, 32'h0, 2'd0, 1'b1);
    cyc(1'b1, 32'h0000_2000, 2'd1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 32'h0, 2'd2, 1'b1);
      n_checks++;
      if (obs_v !== exp_v || ob_ia !== 32'h0000_1008 || ob_ireq !== 1'b1 || ob_avail !== 2'd0) begin
        n_err++; $display("FAIL drain_hold cyc%0d: got %h required %h (ia 00001008)", i, obs_v, exp_v);
      end
    end
    hold_ack = 1'b0;
    cyc(1'b0, 32'h0, 2'd0, 1'b1);
    cyc(1'b0, 32'h0, 2'd0, 1'b1);
    n_checks++;
    if (obs_v !== exp_v || ob_ia !== 32'h0000_2000 || ob_ireq !== 1'b1 || ob_pc !== 32'h0000_2000) begin
      n_err++; $display("FAIL drain_restart: got %h required %h (ia 00002000)", obs_v, exp_v);
    end
  endtask

  task automatic test_stream();
    logic [31:0] pc, a, w;
    logic [15:0] hw;
    ack_delay = -1; cur_delay = 1; salt = 32'h0;
    pc = $urandom & 32'hFFFF_FFFE;
    cyc(1'b1, pc, 2'd0, 1'b1);
    for (int i = 0; i < 80; i++) begin
      cyc(1'b0, 32'h0, (i % 2) ? 2'd2 : 2'd1, 1'b1);
      n_checks++;
      if (obs_v !== exp_v || ob_pc !== pc) begin
        n_err++; $display("FAIL stream cyc%0d: got %h required %h pc=%h", i, obs_v, exp_v, pc);
      end
      for (int k = 0; k < last_cc; k++) begin
        a = ob_pc + 32'(2 * k);
        w = {a[31:2], 2'b00};
        hw = (k == 0) ? ob_hw0 : ob_hw1;
        n_checks++;
        if (hw !== (a[1] ? w[31:16] : w[15:0])) begin
          n_err++; $display("FAIL stream_data at %h: got %h required %h", a, hw, a[1] ? w[31:16] : w[15:0]);
        end
      end
      pc = pc + 32'(2 * last_cc);
    end
  endtask

  task automatic test_random();
    logic fl, ce;
    ack_delay = -1; salt = $urandom;
    for (int i = 0; i < 400; i++) begin
      fl = ($urandom_range(0, 15) == 0);
      ce = ($urandom_range(0, 7) != 0);
      cyc(fl, (i % 50 == 7) ? 32'hFFFF_FFFA : $urandom, 2'($urandom_range(0, 3)), ce);
      n_checks++;
      if (obs_v !== exp_v) begin n_err++; $display("FAIL random cyc%0d: got %h required %h", i, obs_v, exp_v); end
    end
  endtask

  initial begin
    test_reset();
    test_wrap_start();
    test_fill();
    test_odd_flush();
    test_drain();
    test_stream();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
